// File: rtl/axis_pkg.sv
// Shared definitions for the stream arbiter: FSM encoding, width helper and
// the engine input depth that bounds a single grant.
package axis_pkg;

  localparam int C_ENGINE_DEPTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Number of bits needed to hold 'value' (1 for value 1, 3 for value 7, 4 for 8).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry order-preserving output buffer. 'full' is a flop so the upstream
// ready it gates never depends combinationally on the downstream ready.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         pop;

  assign pop = (count_q != 2'd0) && pop_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    full_d  = (count_d == 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset as well because the output port reads it
      // directly and must show zeros out of reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      full_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop sample pre-edge values,
      // independent of statement order.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign full      = full_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one AXI4-Stream engine. A grant
// lasts one packet, capped at C_MAX_BEATS beats; the source index rides on TID.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_NUM_REQ          = 2,
  parameter int C_MAX_BEATS        = C_ENGINE_DEPTH
) (
  input  logic                                    AXIS_ACLK,
  input  logic                                    AXIS_ARESETN,
  input  logic [C_NUM_REQ-1:0]                    S_AXIS_TVALID,
  output logic [C_NUM_REQ-1:0]                    S_AXIS_TREADY,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [C_NUM_REQ-1:0]                    S_AXIS_TLAST,
  output logic                                    M_AXIS_TVALID,
  input  logic                                    M_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]           M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]         M_AXIS_TSTRB,
  output logic                                    M_AXIS_TLAST,
  output logic [clogb2(C_NUM_REQ-1)-1:0]          M_AXIS_TID,
  output logic                                    busy,
  output logic                                    split_pulse
);

  localparam int DW   = C_AXIS_TDATA_WIDTH;
  localparam int SW   = C_AXIS_TDATA_WIDTH / 8;
  localparam int TIDW = clogb2(C_NUM_REQ - 1);
  localparam int CNTW = clogb2(C_MAX_BEATS);
  localparam int PW   = TIDW + 1 + SW + DW;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(C_MAX_BEATS - 1);

  arb_state_e      state_q, state_d;
  logic [TIDW-1:0] grant_q, grant_d;
  logic [TIDW-1:0] last_grant_q, last_grant_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
  logic            split_q, split_d;

  logic [TIDW-1:0] hi_pick, lo_pick, rr_pick;
  logic            hi_found, lo_found, rr_found;

  logic            sel_valid, sel_last;
  logic [DW-1:0]   sel_data;
  logic [SW-1:0]   sel_strb;
  logic            accept, out_last, skid_full;
  logic [PW-1:0]   skid_out;

  // Requesters above last_grant win over those at or below it, which gives
  // the modulo search order without any wrap-around arithmetic.
  always_comb begin
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int j = 0; j < C_NUM_REQ; j++) begin
      if (S_AXIS_TVALID[j]) begin
        if (j > int'(last_grant_q)) begin
          if (!hi_found) begin
            hi_pick  = TIDW'(j);
            hi_found = 1'b1;
          end
        end else if (!lo_found) begin
          lo_pick  = TIDW'(j);
          lo_found = 1'b1;
        end
      end
    end
    rr_found = hi_found || lo_found;
    rr_pick  = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (grant_q == TIDW'(i)) begin
        sel_valid = S_AXIS_TVALID[i];
        sel_last  = S_AXIS_TLAST[i];
        sel_data  = S_AXIS_TDATA[i*DW +: DW];
        sel_strb  = S_AXIS_TSTRB[i*SW +: SW];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    split_d       = 1'b0;
    S_AXIS_TREADY = '0;
    accept        = 1'b0;
    out_last      = sel_last || (beat_cnt_q == LAST_CNT);
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        for (int i = 0; i < C_NUM_REQ; i++) begin
          if (grant_q == TIDW'(i)) S_AXIS_TREADY[i] = !skid_full;
        end
        accept = sel_valid && !skid_full;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNTW'(1);
          if (out_last) begin
            // A cap-forced end leaves the rest of the source packet to
            // compete again as a fresh packet.
            beat_cnt_d   = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
            split_d      = !sel_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= TIDW'(C_NUM_REQ - 1);
      beat_cnt_q   <= '0;
      split_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      split_q      <= split_d;
    end
  end

  axis_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk      (AXIS_ACLK),
    .rst_n    (AXIS_ARESETN),
    .push     (accept),
    .push_data({grant_q, out_last, sel_strb, sel_data}),
    .full     (skid_full),
    .pop_ready(M_AXIS_TREADY),
    .out_valid(M_AXIS_TVALID),
    .out_data (skid_out)
  );

  assign {M_AXIS_TID, M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TDATA} = skid_out;
  assign busy        = (state_q == GRANT);
  assign split_pulse = split_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed scenarios plus a random
// run, all scored against a per-source packet model.
module tb_axis_rr_arbiter;

  localparam int W    = 32;
  localparam int SW   = 4;
  localparam int N    = 2;
  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast;
  logic [N*W-1:0]  s_tdata;
  logic [N*SW-1:0] s_tstrb;
  logic            m_tvalid, m_tready, m_tlast;
  logic [W-1:0]    m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [0:0]      m_tid;
  logic            busy, split_pulse;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_NUM_REQ         (N),
    .C_MAX_BEATS       (MAXB)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TREADY(s_tready),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TSTRB (s_tstrb),
    .S_AXIS_TLAST (s_tlast),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TREADY(m_tready),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TSTRB (m_tstrb),
    .M_AXIS_TLAST (m_tlast),
    .M_AXIS_TID   (m_tid),
    .busy         (busy),
    .split_pulse  (split_pulse)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];

  int total = 0;
  int bad   = 0;
  int cyc = 0, vprob = 100, mprob = 100;
  int seg_len = 0, seg_tid = 0, seg_first = 0;
  int acc_total = 0, out_total = 0, occ_max = 0;
  int exp_splits = 0, obs_splits = 0;
  int acc_cnt [N];
  int pkt_tid_q[$], pkt_len_q[$], pkt_first_q[$], pkt_last_q[$];
  int acc_cyc_q[$], out_cyc_q[$];
  logic [N-1:0] hs;
  logic prev_stall = 1'b0;
  logic [W+SW+1:0] prev_out;
  logic saw_low = 1'b0, last_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input int src, input int len, input logic [W-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = base + W'(k);
      b.strb = SW'($urandom_range(15));
      b.last = (k == len - 1);
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  task automatic clear_logs();
    pkt_tid_q.delete(); pkt_len_q.delete(); pkt_first_q.delete(); pkt_last_q.delete();
    acc_cyc_q.delete(); out_cyc_q.delete();
  endtask

  // Model of one output beat: it must be the oldest unsent beat of its source,
  // and TLAST is the source TLAST or the cap on the packet length.
  task automatic score();
    int    t;
    beat_t b;
    logic  exp_last;
    t = int'(m_tid);
    out_total++;
    out_cyc_q.push_back(cyc);
    if (seg_len == 0) begin
      seg_tid   = t;
      seg_first = cyc;
    end else begin
      check("m_tid_in_pkt", 64'(t), 64'(seg_tid));
    end
    check("m_exp_avail", 64'(exp_q[t].size() != 0), 64'd1);
    if (exp_q[t].size() != 0) begin
      b = exp_q[t].pop_front();
      check("m_data_strb", {m_tdata, m_tstrb}, {b.data, b.strb});
      exp_last = b.last || (seg_len == MAXB - 1);
      check("m_tlast", 64'(m_tlast), 64'(exp_last));
      if (exp_last && !b.last) exp_splits++;
    end
    if (m_tlast) begin
      pkt_tid_q.push_back(t);
      pkt_len_q.push_back(seg_len + 1);
      pkt_first_q.push_back(seg_first);
      pkt_last_q.push_back(cyc);
      seg_len = 0;
    end else begin
      seg_len++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
    hs = s_tvalid & s_tready;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        acc_cnt[i]++;
        acc_total++;
        acc_cyc_q.push_back(cyc);
      end
    end
    if (prev_stall)
      check("m_hold", {m_tvalid, m_tid, m_tlast, m_tstrb, m_tdata}, {1'b1, prev_out});
    prev_stall = m_tvalid && !m_tready;
    prev_out   = {m_tid, m_tlast, m_tstrb, m_tdata};
    if (split_pulse) obs_splits++;
    if (busy && !s_tready[0]) saw_low = 1'b1;
    last_busy = busy;
    if (m_tvalid && m_tready) score();
    if (acc_total - out_total > occ_max) occ_max = acc_total - out_total;
  endtask

  task automatic drive();
    logic keep;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      keep = s_tvalid[i] && !hs[i];
      if (src_q[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
      end else begin
        if (!keep) s_tvalid[i] = ($urandom_range(99) < vprob);
        s_tdata[i*W +: W]   = src_q[i][0].data;
        s_tstrb[i*SW +: SW] = src_q[i][0].strb;
        s_tlast[i]          = src_q[i][0].last;
      end
    end
    m_tready = ($urandom_range(99) < mprob);
  endtask

  task automatic cycle();
    sample();
    drive();
  endtask

  function automatic logic quiet();
    logic q;
    q = !m_tvalid && !busy;
    for (int i = 0; i < N; i++) q = q && (src_q[i].size() == 0) && (exp_q[i].size() == 0);
    return q;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !quiet()) begin
      cycle();
      n++;
    end
    check({"drain_", tag}, 64'(quiet()), 64'd1);
    check({"splits_", tag}, 64'(obs_splits), 64'(exp_splits));
  endtask

  initial begin
    int base, n;
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    hs       = '0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb, m_tid, busy, split_pulse}), 64'd0);
    rst_n = 1'b1;

    // Single source, 4-beat packet
    clear_logs();
    base = out_total;
    enqueue(0, 4, 32'hA0);
    n = 0;
    while (n < 40 && out_total - base < 4) begin cycle(); n++; end
    check("t2_out_count", 64'(out_total - base), 64'd4);
    check("t2_acc_count", 64'(acc_cyc_q.size()), 64'd4);
    if (acc_cyc_q.size() == 4 && out_cyc_q.size() == 4)
      for (int k = 0; k < 4; k++) check("t2_latency", 64'(out_cyc_q[k] - acc_cyc_q[k]), 64'd1);
    check("t2_busy_after_last", 64'(last_busy), 64'd0);
    check("t2_pkt", 64'({pkt_tid_q.size(), pkt_tid_q.size() > 0 ? pkt_tid_q[0] : -1, pkt_len_q.size() > 0 ? pkt_len_q[0] : -1}),
          64'({32'd1, 32'd0, 32'd4}));
    drain("t2", 50);

    // 11-beat packet from source 1 gets split; pending source 0 goes between
    clear_logs();
    base = obs_splits;
    enqueue(1, 11, 32'hB00);
    cycle();
    cycle();
    enqueue(0, 2, 32'hC00);
    drain("t4", 100);
    check("t4_split_count", 64'(obs_splits - base), 64'd1);
    check("t4_pkt_count", 64'(pkt_tid_q.size()), 64'd3);
    if (pkt_tid_q.size() == 3) begin
      check("t4_tids", 64'({pkt_tid_q[0], pkt_tid_q[1], pkt_tid_q[2]}), 64'({32'd1, 32'd0, 32'd1}));
      check("t4_lens", 64'({pkt_len_q[0], pkt_len_q[1], pkt_len_q[2]}), 64'({32'd8, 32'd2, 32'd3}));
    end

    // Backpressure mid-packet
    clear_logs();
    base = out_total;
    enqueue(0, 8, 32'hD00);
    n = 0;
    while (n < 40 && out_total - base < 2) begin cycle(); n++; end
    mprob   = 0;
    occ_max = 0;
    saw_low = 1'b0;
    repeat (6) cycle();
    mprob = 100;
    check("t5_occupancy_max", 64'(occ_max), 64'd2);
    check("t5_tready_dropped", 64'(saw_low), 64'd1);
    drain("t5", 60);

    // Reset after beat 2 of a 4-beat packet
    clear_logs();
    base = acc_cnt[0];
    enqueue(0, 4, 32'hE00);
    n = 0;
    while (n < 40 && acc_cnt[0] - base < 2) begin cycle(); n++; end
    check("rst_mid_accepted", 64'(acc_cnt[0] - base), 64'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb, m_tid, busy, split_pulse}), 64'd0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    s_tvalid   = '0;
    hs         = '0;
    seg_len    = 0;
    prev_stall = 1'b0;
    out_total  = acc_total;
    repeat (2) cycle();
    rst_n = 1'b1;

    // Both sources hold 3-beat packets: 0,1,0,1 with one idle cycle between
    clear_logs();
    enqueue(0, 3, 32'hF00);
    enqueue(1, 3, 32'hF10);
    enqueue(0, 3, 32'hF20);
    enqueue(1, 3, 32'hF30);
    drain("t3", 100);
    check("t3_pkt_count", 64'(pkt_tid_q.size()), 64'd4);
    if (pkt_tid_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t3_tid", 64'(pkt_tid_q[k]), 64'(k % 2));
        check("t3_len", 64'(pkt_len_q[k]), 64'd3);
      end
      for (int k = 0; k < 3; k++) check("t3_gap", 64'(pkt_first_q[k+1] - pkt_last_q[k]), 64'd2);
    end

    // Random traffic with random valid and ready
    vprob = 70;
    mprob = 70;
    for (int p = 0; p < 15; p++) begin
      enqueue(0, $urandom_range(1, 12), 32'h1000_0000 + 32'(p * 256));
      enqueue(1, $urandom_range(1, 12), 32'h2000_0000 + 32'(p * 256));
    end
    drain("random", 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
